// File: rtl/ecc16_pkg.sv
// ECC16 SEC-DED shared constants, types and helpers.
// Check-bit masks, syndrome decode table, pipeline bundles.
package ecc16_pkg;

    localparam int DATA_W = 16;
    localparam int PAR_W  = 6;
    localparam int HAM_W  = 5;

    // Data bits covered by each Hamming check bit.
    // Data bit i sits at codeword position 3,5,6,7,9..15,17..21.
    localparam logic [DATA_W-1:0] CHK0_MASK = 16'hAD5B;
    localparam logic [DATA_W-1:0] CHK1_MASK = 16'h366D;
    localparam logic [DATA_W-1:0] CHK2_MASK = 16'hC78E;
    localparam logic [DATA_W-1:0] CHK3_MASK = 16'h07F0;
    localparam logic [DATA_W-1:0] CHK4_MASK = 16'hF800;

    // Syndrome -> data bit: bit 4 = syndrome names a data bit,
    // bits [3:0] = index of that data bit.
    localparam logic [4:0] SYN_DECODE [32] = '{
        5'h00, 5'h00, 5'h00, 5'h10,
        5'h00, 5'h11, 5'h12, 5'h13,
        5'h00, 5'h14, 5'h15, 5'h16,
        5'h17, 5'h18, 5'h19, 5'h1A,
        5'h00, 5'h1B, 5'h1C, 5'h1D,
        5'h1E, 5'h1F, 5'h00, 5'h00,
        5'h00, 5'h00, 5'h00, 5'h00,
        5'h00, 5'h00, 5'h00, 5'h00
    };

    typedef enum logic [1:0] {
        SYN_CLEAN  = 2'd0,
        SYN_DATA   = 2'd1,
        SYN_PARITY = 2'd2,
        SYN_UNCORR = 2'd3
    } syn_class_e;

    // Stage 1 -> stage 2 bundle.
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
        logic [HAM_W-1:0]  syn;
        logic              ov;
    } s1_t;

    // Stage 2 classification result.
    typedef struct packed {
        logic              sbe;
        logic              dbe;
        logic [DATA_W-1:0] data;
    } fix_t;

    // A zero or single-hot syndrome points at a check bit,
    // or at the overall parity bit itself.
    function automatic logic is_parity_syn(input logic [HAM_W-1:0] syn);
        return (syn & (syn - 5'd1)) == 5'd0;
    endfunction

    function automatic syn_class_e classify(
        input logic [HAM_W-1:0] syn,
        input logic             ov
    );
        syn_class_e cls;
        cls = SYN_UNCORR;
        if (!ov) begin
            cls = (syn == 5'd0) ? SYN_CLEAN : SYN_UNCORR;
        end else if (SYN_DECODE[syn][4]) begin
            cls = SYN_DATA;
        end else if (is_parity_syn(syn)) begin
            cls = SYN_PARITY;
        end
        return cls;
    endfunction

endpackage

// File: rtl/ecc16_syndrome.sv
// ECC16 syndrome generator, purely combinational.
// Recomputes check bits with encoder equations and compares.
module ecc16_syndrome
    import ecc16_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [PAR_W-1:0]  parity,
    output logic [HAM_W-1:0]  syn,
    output logic              ov
);

    logic [HAM_W-1:0] chk;

    // Encoder check bits, then syndrome and overall parity.
    always_comb begin
        chk[0] = ^(data & CHK0_MASK);
        chk[1] = ^(data & CHK1_MASK);
        chk[2] = ^(data & CHK2_MASK);
        chk[3] = ^(data & CHK3_MASK);
        chk[4] = ^(data & CHK4_MASK);
        syn    = chk ^ parity[HAM_W-1:0];
        ov     = ^{data, parity};
    end

endmodule

// File: rtl/ecc16_decoder_pipe.sv
// ECC16 SEC-DED receive decoder, two-stage pipeline.
// Corrects single-bit errors, flags uncorrectable words, counts both.
module ecc16_decoder_pipe
    import ecc16_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] dec_in,
    input  logic [PAR_W-1:0]  parity_in,
    input  logic              valid_in,
    input  logic              cnt_clear,
    output logic [DATA_W-1:0] dec_out,
    output logic              valid_out,
    output logic              sbe_out,
    output logic              dbe_out,
    output logic [PAR_W-1:0]  syndrome_out,
    output logic              sbe_sticky,
    output logic              dbe_sticky,
    output logic [CNT_W-1:0]  sbe_cnt,
    output logic [CNT_W-1:0]  dbe_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [HAM_W-1:0] syn_c;
    logic             ov_c;
    s1_t              s1_q;
    fix_t             fix_c;
    syn_class_e       cls_c;
    logic [4:0]       dec_entry;
    logic             sbe_evt;
    logic             dbe_evt;

    ecc16_syndrome u_syndrome (
        .data   (dec_in),
        .parity (parity_in),
        .syn    (syn_c),
        .ov     (ov_c)
    );

    // Stage 1: capture data with its syndrome every cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= '0;
        end else begin
            s1_q.valid <= valid_in;
            s1_q.data  <= dec_in;
            s1_q.syn   <= syn_c;
            s1_q.ov    <= ov_c;
        end
    end

    // Classify the stage 1 syndrome and repair a single data bit.
    always_comb begin
        fix_c     = '0;
        fix_c.data = s1_q.data;
        cls_c     = classify(s1_q.syn, s1_q.ov);
        dec_entry = SYN_DECODE[s1_q.syn];
        unique case (cls_c)
            SYN_CLEAN: begin
                fix_c.sbe = 1'b0;
            end
            SYN_DATA: begin
                fix_c.sbe  = 1'b1;
                fix_c.data = s1_q.data ^ (16'd1 << dec_entry[3:0]);
            end
            SYN_PARITY: begin
                fix_c.sbe = 1'b1;
            end
            SYN_UNCORR: begin
                fix_c.dbe = 1'b1;
            end
            default: begin
                fix_c.dbe = 1'b1;
            end
        endcase
    end

    // Stage 2: flags follow every slot, data and syndrome only valid ones.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_out    <= 1'b0;
            sbe_out      <= 1'b0;
            dbe_out      <= 1'b0;
            dec_out      <= '0;
            syndrome_out <= '0;
        end else begin
            valid_out <= s1_q.valid;
            sbe_out   <= s1_q.valid & fix_c.sbe;
            dbe_out   <= s1_q.valid & fix_c.dbe;
            if (s1_q.valid) begin
                dec_out      <= fix_c.data;
                syndrome_out <= {s1_q.ov, s1_q.syn};
            end
        end
    end

    assign sbe_evt = valid_out & sbe_out;
    assign dbe_evt = valid_out & dbe_out;

    // Saturating error counters; a clear beats a same-cycle event.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sbe_cnt <= '0;
            dbe_cnt <= '0;
        end else if (cnt_clear) begin
            sbe_cnt <= '0;
            dbe_cnt <= '0;
        end else begin
            if (sbe_evt && sbe_cnt != CNT_MAX) begin
                sbe_cnt <= sbe_cnt + 1'b1;
            end
            if (dbe_evt && dbe_cnt != CNT_MAX) begin
                dbe_cnt <= dbe_cnt + 1'b1;
            end
        end
    end

    // Sticky error flags, cleared together with the counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sbe_sticky <= 1'b0;
            dbe_sticky <= 1'b0;
        end else if (cnt_clear) begin
            sbe_sticky <= 1'b0;
            dbe_sticky <= 1'b0;
        end else begin
            if (sbe_evt) begin
                sbe_sticky <= 1'b1;
            end
            if (dbe_evt) begin
                dbe_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ecc16_decoder_pipe.sv
// Self-checking bench for ecc16_decoder_pipe.
// Codeword-position reference model, directed and random words.
module tb_ecc16_decoder_pipe;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic             clock;
    logic             reset_n;
    logic [15:0]      dec_in;
    logic [5:0]       parity_in;
    logic             valid_in;
    logic             cnt_clear;
    logic [15:0]      dec_out;
    logic             valid_out;
    logic             sbe_out;
    logic             dbe_out;
    logic [5:0]       syndrome_out;
    logic             sbe_sticky;
    logic             dbe_sticky;
    logic [CNT_W-1:0] sbe_cnt;
    logic [CNT_W-1:0] dbe_cnt;

    int total = 0;
    int bad   = 0;

    // Codeword position of each data bit.
    int DPOS [16] = '{3, 5, 6, 7, 9, 10, 11, 12,
                      13, 14, 15, 17, 18, 19, 20, 21};

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic [5:0]  p;
    } in_t;

    in_t q[$];

    logic             e_valid, e_sbe, e_dbe;
    logic [15:0]      e_dec;
    logic [5:0]       e_syn;
    logic [CNT_W-1:0] e_scnt, e_dcnt;
    logic             e_sst, e_dst;

    ecc16_decoder_pipe #(.CNT_W(CNT_W)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .dec_in       (dec_in),
        .parity_in    (parity_in),
        .valid_in     (valid_in),
        .cnt_clear    (cnt_clear),
        .dec_out      (dec_out),
        .valid_out    (valid_out),
        .sbe_out      (sbe_out),
        .dbe_out      (dbe_out),
        .syndrome_out (syndrome_out),
        .sbe_sticky   (sbe_sticky),
        .dbe_sticky   (dbe_sticky),
        .sbe_cnt      (sbe_cnt),
        .dbe_cnt      (dbe_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Encoder: check bit k is parity of data positions with bit k set.
    function automatic logic [5:0] enc_par(input logic [15:0] d);
        logic [5:0] p;
        p = '0;
        for (int k = 0; k < 5; k++)
            for (int i = 0; i < 16; i++)
                if (d[i] && ((DPOS[i] >> k) & 1) == 1) p[k] = ~p[k];
        p[5] = ^d ^ ^p[4:0];
        return p;
    endfunction

    // Syndrome = XOR of positions of all set codeword bits.
    task automatic ref_decode(input in_t r, output logic sbe,
                              output logic dbe, output logic [15:0] d,
                              output logic [5:0] syn);
        int s;
        int hit;
        logic ov;
        s = 0;
        hit = -1;
        for (int i = 0; i < 16; i++) if (r.d[i]) s = s ^ DPOS[i];
        for (int k = 0; k < 5; k++) if (r.p[k]) s = s ^ (1 << k);
        ov = ^{r.d, r.p};
        d = r.d;
        sbe = 1'b0;
        dbe = 1'b0;
        if (!ov) begin
            dbe = (s != 0);
        end else begin
            for (int i = 0; i < 16; i++) if (DPOS[i] == s) hit = i;
            if (hit >= 0) begin
                d[hit] = ~d[hit];
                sbe = 1'b1;
            end else if (s == 0 || s == 1 || s == 2 || s == 4 ||
                         s == 8 || s == 16) begin
                sbe = 1'b1;
            end else begin
                dbe = 1'b1;
            end
        end
        syn = {ov, 5'(s)};
    endtask

    task automatic check_all();
        chk("valid_out", 32'(valid_out), 32'(e_valid));
        chk("sbe_out", 32'(sbe_out), 32'(e_sbe));
        chk("dbe_out", 32'(dbe_out), 32'(e_dbe));
        chk("dec_out", 32'(dec_out), 32'(e_dec));
        chk("syndrome_out", 32'(syndrome_out), 32'(e_syn));
        chk("sbe_cnt", 32'(sbe_cnt), 32'(e_scnt));
        chk("dbe_cnt", 32'(dbe_cnt), 32'(e_dcnt));
        chk("sbe_sticky", 32'(sbe_sticky), 32'(e_sst));
        chk("dbe_sticky", 32'(dbe_sticky), 32'(e_dst));
    endtask

    task automatic model_reset();
        q.delete();
        e_valid = 0; e_sbe = 0; e_dbe = 0;
        e_dec = '0; e_syn = '0;
        e_scnt = '0; e_dcnt = '0;
        e_sst = 0; e_dst = 0;
    endtask

    // One clock: drive, advance model, compare after the edge.
    task automatic step(input logic v, input logic [15:0] d,
                        input logic [5:0] p, input logic clr);
        in_t r;
        logic s, b;
        logic [15:0] dd;
        logic [5:0] sy;
        valid_in = v;
        dec_in = d;
        parity_in = p;
        cnt_clear = clr;
        r.v = v; r.d = d; r.p = p;
        q.push_back(r);
        if (clr) begin
            e_scnt = '0; e_dcnt = '0; e_sst = 0; e_dst = 0;
        end else begin
            if (e_valid && e_sbe) begin
                e_sst = 1;
                if (e_scnt != CMAX) e_scnt = e_scnt + 1'b1;
            end
            if (e_valid && e_dbe) begin
                e_dst = 1;
                if (e_dcnt != CMAX) e_dcnt = e_dcnt + 1'b1;
            end
        end
        @(posedge clock);
        #1;
        e_valid = 0; e_sbe = 0; e_dbe = 0;
        if (q.size() == 2) begin
            r = q.pop_front();
            if (r.v) begin
                ref_decode(r, s, b, dd, sy);
                e_valid = 1; e_sbe = s; e_dbe = b;
                e_dec = dd; e_syn = sy;
            end
        end
        cnt_clear = 0;
        check_all();
    endtask

    task automatic idle();
        step(1'b0, 16'h0, 6'h0, 1'b0);
    endtask

    task automatic rand_word();
        logic [21:0] cw;
        logic [15:0] d;
        int nf, a, b2;
        d = 16'($urandom);
        cw = {enc_par(d), d};
        nf = $urandom_range(0, 2);
        a = $urandom_range(0, 21);
        b2 = (a + $urandom_range(1, 21)) % 22;
        if (nf >= 1) cw[a] = ~cw[a];
        if (nf == 2) cw[b2] = ~cw[b2];
        if ($urandom_range(0, 19) == 0) cw[21:16] = 6'($urandom);
        step($urandom_range(0, 9) < 8, cw[15:0], cw[21:16],
             $urandom_range(0, 19) == 0);
    endtask

    initial begin
        reset_n = 0;
        valid_in = 0;
        dec_in = '0;
        parity_in = '0;
        cnt_clear = 0;
        model_reset();
        #12;
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_dec", 32'(dec_out), 32'd0);
        chk("rst_cnt", 32'(sbe_cnt), 32'd0);
        @(negedge clock);
        reset_n = 1;

        step(1, 16'h0000, 6'h00, 0);
        idle();
        chk("clean_valid", 32'(valid_out), 32'd1);
        chk("clean_dec", 32'(dec_out), 32'h0000);
        chk("clean_syn", 32'(syndrome_out), 32'h00);

        step(1, 16'hFFDF, 6'h1E, 0);
        idle();
        chk("d5_dec", 32'(dec_out), 32'hFFFF);
        chk("d5_sbe", 32'(sbe_out), 32'd1);
        chk("d5_syn", 32'(syndrome_out), 32'h2A);
        idle();
        chk("d5_cnt", 32'(sbe_cnt), 32'd1);

        step(1, 16'hFFFF, 6'h3E, 0);
        idle();
        chk("p5_dec", 32'(dec_out), 32'hFFFF);
        chk("p5_sbe", 32'(sbe_out), 32'd1);
        chk("p5_syn", 32'(syndrome_out), 32'h20);

        step(1, 16'h0003, 6'h00, 0);
        idle();
        chk("dbl_dbe", 32'(dbe_out), 32'd1);
        chk("dbl_dec", 32'(dec_out), 32'h0003);
        chk("dbl_syn", 32'(syndrome_out), 32'h06);
        idle();
        chk("dbl_sticky", 32'(dbe_sticky), 32'd1);

        step(1, 16'h0000, 6'h1F, 0);
        idle();
        chk("inv_dbe", 32'(dbe_out), 32'd1);
        chk("inv_syn", 32'(syndrome_out), 32'h3F);
        idle();

        for (int i = 0; i < 20; i++) step(1, 16'hFFDF, 6'h1E, 0);
        idle();
        idle();
        idle();
        chk("sat_cnt", 32'(sbe_cnt), 32'hF);

        step(1, 16'hFFDF, 6'h1E, 0);
        idle();
        chk("clr_evt", 32'(sbe_out), 32'd1);
        step(0, 16'h0, 6'h0, 1);
        chk("clr_cnt", 32'(sbe_cnt), 32'd0);
        chk("clr_sticky", 32'(sbe_sticky), 32'd0);

        for (int i = 0; i < 300; i++) rand_word();

        #2;
        reset_n = 0;
        #1;
        chk("mid_valid", 32'(valid_out), 32'd0);
        chk("mid_dec", 32'(dec_out), 32'd0);
        chk("mid_syn", 32'(syndrome_out), 32'd0);
        chk("mid_sbecnt", 32'(sbe_cnt), 32'd0);
        chk("mid_dbecnt", 32'(dbe_cnt), 32'd0);
        chk("mid_sticky", 32'({sbe_sticky, dbe_sticky}), 32'd0);
        model_reset();
        valid_in = 0;
        cnt_clear = 0;
        @(negedge clock);
        reset_n = 1;

        for (int i = 0; i < 200; i++) rand_word();
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ecc16_decoder_pipe.md
Name: ecc16_decoder_pipe

Overview:
- Receive-side companion of the ECC16 16-data/6-parity encoder: checks and corrects each 22-bit word (16 data + 6 parity) arriving from the far end of the ALCT link.
- SEC-DED: corrects any single-bit error, flags double-bit and invalid-syndrome words as uncorrectable.
- Two-stage registered pipeline with valid qualifier, sticky error flags and saturating error counters for VME readout.

Parameters:
CNT_W, 16, width of the single-error and double-error counters.

Ports:
clock  in  1  main clock
reset_n  in  1  asynchronous active-low reset
dec_in  in  16  received data
parity_in  in  6  received parity; bits [4:0] Hamming check, bit [5] overall parity
valid_in  in  1  dec_in/parity_in valid this cycle
cnt_clear  in  1  synchronous clear of counters and sticky flags
dec_out  out  16  corrected data
valid_out  out  1  dec_out qualifier
sbe_out  out  1  single-bit error corrected on this word
dbe_out  out  1  uncorrectable error on this word
syndrome_out  out  6  {overall, syn[4:0]} of this word
sbe_sticky  out  1  any SBE since last clear
dbe_sticky  out  1  any DBE since last clear
sbe_cnt  out  CNT_W  saturating SBE count
dbe_cnt  out  CNT_W  saturating DBE count

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. All outputs and internal registers reset to 0.
- Stage 1, registered: recompute chk[4:0] from dec_in with the encoder equations.
  - syn[4:0] = chk[4:0] ^ parity_in[4:0].
  - ov = XOR of all 16 data bits and all 6 parity bits (0 when clean).
  - Stage 1 registers data, syn, ov and valid.
- Syndrome for data bit d0..d15: 3,5,6,7,9,10,11,12,13,14,15,17,18,19,20,21. Check bit k gives 1<<k.
- Stage 2, registered, classify:
  - ov=0, syn=0: clean; data passes unchanged.
  - ov=1, syn in data table: flip that data bit; sbe=1.
  - ov=1, syn=0 or a power of two: parity-only error; data unchanged; sbe=1.
  - ov=1, syn any other value (1xx11-type, >21): dbe=1; data passed uncorrected.
  - ov=0, syn≠0: dbe=1; data passed uncorrected.
- Latency: exactly 2 clocks from valid_in to valid_out. Full throughput, one word per clock, no backpressure.
- When valid_in=0: the pipeline still advances. valid_out, sbe_out and dbe_out are 0 for that slot. dec_out and syndrome_out hold their last values.
- Counters:
  - Increment on valid_out&sbe_out or valid_out&dbe_out respectively.
  - Saturate at all ones with no wrap.
  - Sticky flags set on the same condition.
- cnt_clear: clears counters and sticky flags next edge. If an error event lands in the same cycle, the clear wins and the event is not counted. cnt_clear does not affect the pipeline.
- Reset mid-stream: in-flight words are discarded; valid_out=0 until 2 clocks after the first valid_in following reset release.

Decomposition:
- Shared package holds:
  - ECC16 check-bit masks, one 16-bit localparam per check bit.
  - 32-entry syndrome-to-bit-index decode constant.
  - Width constants 16 and 6.
- One natural sub-module: ecc16_syndrome. Combinational; computes syn[4:0] and ov from data+parity and reuses the encoder equations. Instantiated in stage 1.

Test Plan:
- dec_in=16'h0000, parity=6'h00, valid_in=1 -> 2 clocks later dec_out=0000, valid_out=1, sbe=dbe=0, syndrome_out=0.
- dec_in=16'hFFDF (d5 flipped from FFFF), parity=6'h1E -> dec_out=FFFF, sbe_out=1, syndrome_out={1,5'd10}, sbe_cnt=1.
- dec_in=16'hFFFF, parity=6'h3E (bit5 flipped) -> dec_out=FFFF, sbe_out=1, syndrome_out=6'h20.
- dec_in=16'h0003, parity=6'h00 -> dbe_out=1, syndrome_out={0,5'd6}, dec_out=0003, dbe_sticky=1.
- dec_in=16'h0000, parity=6'h1F -> syn=31, ov=1, dbe_out=1 (invalid syndrome).
- CNT_W=4: 20 consecutive SBE words -> sbe_cnt holds 4'hF. Assert cnt_clear together with one SBE word -> sbe_cnt=0, sbe_sticky=0. Pulse reset_n low mid-stream -> all outputs 0 immediately.
